// File: rtl/ofm_stream_drain_pkg.sv
// Shared definitions for the OFM stream drain: controller state encoding and
// address-width derivation from the OFM RAM size.
package ofm_stream_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FINISH = 2'd3
  } drain_state_e;

  localparam int OFM_RAM_SIZE_DEF = 32'd2378675;

  function automatic int addr_width(input int size);
    return (size > 32'sd1) ? $clog2(size) : 32'sd1;
  endfunction

  localparam int ADDR_W_DEF = addr_width(OFM_RAM_SIZE_DEF);

endpackage

// File: rtl/ofm_stream_drain_fifo.sv
// First-word-fall-through output buffer for the OFM drain; dout always shows
// the oldest stored word straight from the storage registers.
module ofm_drain_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1),
  parameter int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok_s) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ofm_stream_drain.sv
// Reads a programmed OFM RAM region after the CNN finishes and streams it out
// as valid/ready beats; read issue is credit-limited so the buffer never overflows.
module ofm_stream_drain
  import ofm_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int OFM_RAM_SIZE = 2378675,
  parameter int ADDR_W       = addr_width(OFM_RAM_SIZE),
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_drain,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     num_words,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OFM_RAM_SIZE - 1);

  drain_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     num_q, num_d;
  logic [ADDR_W-1:0]     issued_q, issued_d;
  logic [ADDR_W-1:0]     sent_q, sent_d;
  logic [RD_LATENCY-1:0] vpipe_q;
  logic                  rd_en_s;
  logic                  credit_ok_s;
  logic                  fire_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic [DATA_WIDTH-1:0] fifo_dout_s;
  int                    inflight_s;

  ofm_drain_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vpipe_q[RD_LATENCY-1]),
    .pop_i   (fire_s),
    .din_i   (ram_rd_data),
    .dout_o  (fifo_dout_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s),
    .count_o (fifo_count_s)
  );

  // Reads in flight plus words buffered must fit in the FIFO before issuing another.
  assign inflight_s  = $countones(vpipe_q);
  assign credit_ok_s = !fifo_full_s && ((int'(fifo_count_s) + inflight_s) < FIFO_DEPTH);
  assign fire_s      = m_valid && m_ready;

  assign m_valid     = !fifo_empty_s;
  assign m_data      = fifo_dout_s;
  assign m_last      = m_valid && (sent_q == (num_q - ONE));
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_FLUSH);
  assign done        = (state_q == ST_FINISH);
  assign ram_rd_en   = rd_en_s;
  assign ram_rd_addr = addr_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    num_d    = num_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    rd_en_s  = 1'b0;
    if (fire_s) sent_d = sent_q + ONE;
    else        sent_d = sent_q;
    case (state_q)
      ST_IDLE: begin
        if (start_drain) begin
          addr_d   = base_addr;
          num_d    = num_words;
          issued_d = '0;
          sent_d   = '0;
          // An empty region passes through FLUSH, which exits at once.
          state_d  = (num_words == '0) ? ST_FLUSH : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok_s) begin
          rd_en_s  = 1'b1;
          addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE;
          issued_d = issued_q + ONE;
          if (issued_d == num_q) state_d = ST_FLUSH;
          else                   state_d = ST_ISSUE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_FLUSH: begin
        if ((inflight_s == 32'sd0) && (sent_d == num_q)) state_d = ST_FINISH;
        else                                             state_d = ST_FLUSH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
    end
  end

  // Read-valid pipe mirrors the RAM latency; clearing it drops in-flight data on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q[0] <= rd_en_s;
      for (int i = 1; i < RD_LATENCY; i++) vpipe_q[i] <= vpipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_ofm_stream_drain.sv
// Directed bench for ofm_stream_drain with a one-cycle-latency OFM RAM model.
module tb_ofm_stream_drain;

  localparam int DW   = 64;
  localparam int SIZE = 2378675;
  localparam int AW   = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_drain;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_words;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DW-1:0] beat_q[$];
  bit            last_q[$];
  logic [AW-1:0] rdaddr_q[$];
  int            done_cnt, busy_cnt, max_out, stall_bad;

  ofm_stream_drain dut (
    .clk         (clk),
    .rst         (rst),
    .start_drain (start_drain),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {10'h2A5, a, 10'h15A, a ^ 22'h3F0F0F};
  endfunction

  function automatic logic [AW-1:0] wrap_add(input int b, input int i);
    int s;
    s = b + i;
    if (s >= SIZE) s = s - SIZE;
    return AW'(s);
  endfunction

  // OFM RAM model: data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram_word(ram_rd_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs one drain and records reads, handshaken beats, done/busy cycles and stall behaviour.
  task automatic run_drain(input int b, input int n, input int mode, input int ncyc, input int inj_beat);
    int issued = 0;
    int popped = 0;
    bit stall_prev = 1'b0;
    bit injected = 1'b0;
    logic [DW-1:0] prev_data = '0;
    beat_q.delete();
    last_q.delete();
    rdaddr_q.delete();
    done_cnt = 0; busy_cnt = 0; max_out = 0; stall_bad = 0;
    base_addr   = AW'(b);
    num_words   = AW'(n);
    start_drain = 1'b1;
    m_ready     = (mode == 1) ? 1'b0 : 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start_drain = 1'b0;
      if (inj_beat >= 0 && !injected && beat_q.size() == inj_beat) begin
        start_drain = 1'b1;
        base_addr   = AW'(b + 777);
        num_words   = AW'(3);
        injected    = 1'b1;
      end
      if (mode == 1)      m_ready = (c % 2 == 1);
      else if (mode == 2) m_ready = (beat_q.size() < 5);
      else                m_ready = 1'b1;
      if (ram_rd_en) begin
        rdaddr_q.push_back(ram_rd_addr);
        issued++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (stall_prev && (!m_valid || m_data !== prev_data)) stall_bad++;
      if (m_valid && m_ready) begin
        beat_q.push_back(m_data);
        last_q.push_back(m_last);
        popped++;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
    end
    start_drain = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW+DW+5:0] obs;
    rst = 1'b1; start_drain = 1'b0; base_addr = '0; num_words = '0; m_ready = 1'b0;
    ram_rd_data = '0;
    step(); step();
    obs = {ram_rd_en, ram_rd_addr, m_valid, m_data, m_last, busy, done, 1'b0};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [4:0] exp_ctl, obs_ctl;
    bit rd_e, mv_e;
    base_addr = AW'(100); num_words = AW'(8); m_ready = 1'b1; start_drain = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start_drain = 1'b0;
      rd_e = (c >= 1 && c <= 8);
      mv_e = (c >= 3 && c <= 10);
      exp_ctl = {rd_e, mv_e, (c == 10), (c >= 1 && c <= 10), (c == 11)};
      obs_ctl = {ram_rd_en, m_valid, m_last, busy, done};
      vectors++;
      if (obs_ctl !== exp_ctl) begin
        miscompares++;
        $display("FAIL basic_ctl c=%0d got=%b exp=%b (rd,valid,last,busy,done)", c, obs_ctl, exp_ctl);
      end
      if (rd_e) begin
        vectors++;
        if (ram_rd_addr !== AW'(100 + c - 1)) begin
          miscompares++;
          $display("FAIL basic_addr c=%0d got=%0d exp=%0d", c, ram_rd_addr, 100 + c - 1);
        end
      end
      if (mv_e) begin
        vectors++;
        if (m_data !== ram_word(AW'(100 + c - 3))) begin
          miscompares++;
          $display("FAIL basic_data c=%0d got=%h exp=%h", c, m_data, ram_word(AW'(100 + c - 3)));
        end
      end
    end
  endtask

  task automatic test_zero_length();
    logic [3:0] exp_ctl, obs_ctl;
    base_addr = AW'(5); num_words = '0; m_ready = 1'b1; start_drain = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      start_drain = 1'b0;
      exp_ctl = {1'b0, 1'b0, (c == 1), (c == 2)};
      obs_ctl = {ram_rd_en, m_valid, busy, done};
      vectors++;
      if (obs_ctl !== exp_ctl) begin
        miscompares++;
        $display("FAIL zero_ctl c=%0d got=%b exp=%b (rd,valid,busy,done)", c, obs_ctl, exp_ctl);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = AW'(2378673); exp_addr[1] = AW'(2378674);
    exp_addr[2] = AW'(0);       exp_addr[3] = AW'(1);
    run_drain(SIZE - 2, 4, 0, 12, -1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= rdaddr_q.size() || rdaddr_q[i] !== exp_addr[i] ||
          i >= beat_q.size() || beat_q[i] !== ram_word(exp_addr[i]) || last_q[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL wrap_beat i=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                 i, (i < rdaddr_q.size()) ? rdaddr_q[i] : '1, (i < beat_q.size()) ? beat_q[i] : '1,
                 exp_addr[i], ram_word(exp_addr[i]));
      end
    end
    vectors++;
    if (beat_q.size() != 4 || rdaddr_q.size() != 4 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL wrap_counts got beats=%0d reads=%0d done=%0d exp 4/4/1", beat_q.size(), rdaddr_q.size(), done_cnt);
    end
  endtask

  task automatic test_backpressure();
    run_drain(500, 16, 1, 80, -1);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (i >= beat_q.size() || beat_q[i] !== ram_word(wrap_add(500, i)) || last_q[i] !== (i == 15)) begin
        miscompares++;
        $display("FAIL bp_beat i=%0d got=%h exp=%h", i, (i < beat_q.size()) ? beat_q[i] : '1, ram_word(wrap_add(500, i)));
      end
    end
    vectors++;
    if (beat_q.size() != 16 || rdaddr_q.size() != 16) begin
      miscompares++;
      $display("FAIL bp_counts got beats=%0d reads=%0d exp 16/16", beat_q.size(), rdaddr_q.size());
    end
    vectors++;
    if (stall_bad != 0) begin
      miscompares++;
      $display("FAIL bp_stall_stable got=%0d unstable stalls exp=0", stall_bad);
    end
    vectors++;
    if (max_out > 4) begin
      miscompares++;
      $display("FAIL bp_credit got max outstanding=%0d exp<=4", max_out);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL bp_done got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_ignored_start();
    run_drain(2000, 10, 0, 25, 3);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (i >= beat_q.size() || beat_q[i] !== ram_word(AW'(2000 + i)) || last_q[i] !== (i == 9) ||
          i >= rdaddr_q.size() || rdaddr_q[i] !== AW'(2000 + i)) begin
        miscompares++;
        $display("FAIL ign_beat i=%0d got=%h exp=%h", i, (i < beat_q.size()) ? beat_q[i] : '1, ram_word(AW'(2000 + i)));
      end
    end
    vectors++;
    if (beat_q.size() != 10 || rdaddr_q.size() != 10 || done_cnt != 1 || busy_cnt != 12) begin
      miscompares++;
      $display("FAIL ign_counts got beats=%0d reads=%0d done=%0d busy=%0d exp 10/10/1/12",
               beat_q.size(), rdaddr_q.size(), done_cnt, busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW+DW+5:0] obs;
    run_drain(1000, 20, 2, 15, -1);
    vectors++;
    if (beat_q.size() != 5 || m_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre got beats=%0d valid=%b busy=%b exp 5/1/1", beat_q.size(), m_valid, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    obs = {ram_rd_en, ram_rd_addr, m_valid, m_data, m_last, busy, done, 1'b0};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got=%h exp=0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    run_drain(0, 2, 0, 10, -1);
    vectors++;
    if (beat_q.size() != 2 || done_cnt != 1 || rdaddr_q.size() != 2) begin
      miscompares++;
      $display("FAIL rstmid_counts got beats=%0d done=%0d reads=%0d exp 2/1/2", beat_q.size(), done_cnt, rdaddr_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (i >= beat_q.size() || beat_q[i] !== ram_word(AW'(i)) || last_q[i] !== (i == 1)) begin
        miscompares++;
        $display("FAIL rstmid_beat i=%0d got=%h exp=%h", i, (i < beat_q.size()) ? beat_q[i] : '1, ram_word(AW'(i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
